// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder driving a single full_adder cell, LSB first

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rs_next;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_carry;

    full_adder fa (
        .a     (ra[0]),
        .b     (rb[0]),
        .cin   (c),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // New bit enters at the MSB; after WIDTH shifts the LSB-first stream is in order.
    assign rs_next = WIDTH'({fa_sum, rs} >> 1);

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            rs    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        c     <= cin;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    rs  <= rs_next;
                    c   <= fa_carry;
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum   <= rs_next;
                        cout  <= fa_carry;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder at WIDTH=8 and WIDTH=2

module tb_serial_adder;
    logic       clk;
    logic       rst8, start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       rst2, start2, cin2, busy2, done2, cout2;
    logic [1:0] a2, b2, sum2;

    int passed = 0;
    int total  = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // mode 0: plain run; 1: operands scrambled during SHIFT; 2: extra start pulse mid-SHIFT
    task automatic run8(input logic [7:0] ta, input logic [7:0] tbv, input logic tc,
                        input int mode, input string tag);
        logic [8:0] exp;
        logic [8:0] snap;
        int busy_n, done_n, done_at;
        exp = 9'(ta) + 9'(tbv) + 9'(tc);
        snap = '0; busy_n = 0; done_n = 0; done_at = 0;
        @(negedge clk);
        a8 = ta; b8 = tbv; cin8 = tc; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            if (n > 1) @(negedge clk);
            if (busy8) busy_n++;
            if (done8) begin
                done_n++;
                done_at = n;
                snap = {cout8, sum8};
            end
            if (mode == 1 && n == 2) begin a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; end
            if (mode == 2 && n == 3) begin a8 = 8'h01; b8 = 8'h01; start8 = 1'b1; end
            if (mode == 2 && n == 4) start8 = 1'b0;
        end
        chk({tag, "_busy_cycles"}, 33'(busy_n), 33'd8);
        chk({tag, "_done_count"}, 33'(done_n), 33'd1);
        chk({tag, "_done_at"}, 33'(done_at), 33'd9);
        chk({tag, "_result"}, 33'(snap), 33'(exp));
        chk({tag, "_held"}, 33'({cout8, sum8}), 33'(exp));
    endtask

    task automatic run2(input logic [1:0] ta, input logic [1:0] tbv, input logic tc);
        logic [2:0] exp;
        logic [2:0] snap;
        int done_n, done_at;
        exp = 3'(ta) + 3'(tbv) + 3'(tc);
        snap = '0; done_n = 0; done_at = 0;
        @(negedge clk);
        a2 = ta; b2 = tbv; cin2 = tc; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            if (n > 1) @(negedge clk);
            if (done2) begin
                done_n++;
                done_at = n;
                snap = {cout2, sum2};
            end
        end
        chk($sformatf("w2_%0h_%0h_%0h_done", ta, tbv, tc), 33'(done_n), 33'd1);
        chk($sformatf("w2_%0h_%0h_%0h_at", ta, tbv, tc), 33'(done_at), 33'd3);
        chk($sformatf("w2_%0h_%0h_%0h_res", ta, tbv, tc), 33'(snap), 33'(exp));
    endtask

    initial begin
        int done_n;
        rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        rst2 = 1'b1; start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        #3;
        chk("reset8_outputs", 33'({busy8, done8, cout8, sum8}), 33'd0);
        chk("reset2_outputs", 33'({busy2, done2, cout2, sum2}), 33'd0);
        @(negedge clk);
        rst8 = 1'b0; rst2 = 1'b0;

        run8(8'h00, 8'h00, 1'b0, 0, "zero");
        run8(8'hFF, 8'h01, 1'b0, 0, "ff_plus_1");
        run8(8'h3C, 8'h42, 1'b0, 0, "no_residual");
        run8(8'hA5, 8'h5A, 1'b1, 1, "operand_change");
        run8(8'h3C, 8'h42, 1'b0, 2, "start_ignored");

        // Abort mid-SHIFT with an asynchronous reset between clock edges.
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst8 = 1'b1;
        #1;
        chk("async_reset_outputs", 33'({busy8, done8, cout8, sum8}), 33'd0);
        @(negedge clk);
        rst8 = 1'b0;
        done_n = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done8 || busy8) done_n++;
        end
        chk("no_done_after_reset", 33'(done_n), 33'd0);
        run8(8'h80, 8'h80, 1'b1, 0, "after_reset");

        for (int i = 0; i < 16; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), 0, $sformatf("rand%0d", i));

        for (int v = 0; v < 32; v++) begin
            logic [4:0] bits;
            bits = 5'(v);
            run2(bits[4:3], bits[2:1], bits[0]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
